// File: rtl/csm_accumulator.sv
// Accumulate stage behind the carry-save array multiplier. Sums a run of
// unsigned products terminated by a "last" beat. The sum saturates at the top
// of the accumulator range. The sum, beat count and saturation flag are then
// held on a valid/ready result port until downstream takes them.
module csm_accumulator #(
    parameter int unsigned BITSIZE = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    input  logic [2*BITSIZE-1:0]   product,
    input  logic                   prod_last,
    input  logic                   clr,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ACC_W-1:0]       result,
    output logic [CNT_W-1:0]       result_count,
    output logic                   result_sat
);

    localparam int unsigned PW = 2 * BITSIZE;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    if (ACC_W < PW) begin : gen_bad_acc_w
        $error("csm_accumulator: ACC_W must be >= 2*BITSIZE");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic              rv_q, rv_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic              res_sat_q, res_sat_d;

    logic              accept;
    logic [ACC_W-1:0]  acc_base;
    logic [CNT_W-1:0]  cnt_base;
    logic              sat_base;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  acc_upd;
    logic [CNT_W-1:0]  cnt_upd;

    // Beat datapath: a run starting from IDLE ignores stale accumulator state.
    always_comb begin
        prod_ready = (state_q != StHold);
        accept     = prod_valid & prod_ready;
        acc_base   = (state_q == StIdle) ? '0 : acc_q;
        cnt_base   = (state_q == StIdle) ? '0 : count_q;
        sat_base   = (state_q == StIdle) ? 1'b0 : sat_q;
        sum        = {1'b0, acc_base} + {{(ACC_W + 1 - PW){1'b0}}, product};
        ovf        = sum[ACC_W] | sat_base;
        acc_upd    = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        cnt_upd    = (cnt_base == CntMax) ? CntMax : cnt_base + CNT_W'(1);
    end

    // Next-state logic; clr overrides everything, including a result handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sat_d     = sat_q;
        rv_d      = rv_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        res_sat_d = res_sat_q;
        if (clr) begin
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
            rv_d    = 1'b0;
        end else if (state_q == StHold) begin
            if (rv_q && result_ready) begin
                state_d = StIdle;
                acc_d   = '0;
                count_d = '0;
                sat_d   = 1'b0;
                rv_d    = 1'b0;
            end
        end else if (accept) begin
            acc_d   = acc_upd;
            count_d = cnt_upd;
            sat_d   = ovf;
            if (prod_last) begin
                state_d   = StHold;
                rv_d      = 1'b1;
                res_d     = acc_upd;
                res_cnt_d = cnt_upd;
                res_sat_d = ovf;
            end else begin
                state_d = StAccum;
            end
        end
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            rv_q      <= 1'b0;
            res_q     <= '0;
            res_cnt_q <= '0;
            res_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            rv_q      <= rv_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            res_sat_q <= res_sat_d;
        end
    end

    assign result_valid = rv_q;
    assign result       = res_q;
    assign result_count = res_cnt_q;
    assign result_sat   = res_sat_q;

endmodule
